seg_scan_driver: RTL and testbench

- Parametrised time-multiplexed 7-segment scan driver for N_DIGITS common-anode digits, with an internal refresh prescaler and digit counter.
- Sits between the clock/time-keeping logic (hours/minutes BCD digits) and the board's seg/anode pins.
- Adds hex decode, per-digit decimal point and blanking, tear-free frame snapshots, and an optional per-digit blink.

---
 rtl/seg_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: hex decode, per-digit dp/blank, tear-free frame snapshots.
// Optional per-digit blink is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic [N_DIGITS-1:0]   blink_i,
  input  logic                  enable_i,
  output logic [7:0]            seg_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  // Segment pattern {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] dig_q;
  logic [N_DIGITS-1:0]   dp_q, blank_q, blink_q;
  logic                  valid_q;
  logic                  frame_q;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  tick, load, phase;

  assign tick = (presc_q == PRE_LAST);
  assign load = tick && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      idx_q   <= IDX_LAST;
      dig_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      blink_q <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= load;
      seg_q   <= seg_d;
      an_q    <= an_d;
      if (load) begin
        dig_q   <= digits_i;
        dp_q    <= dp_i;
        blank_q <= blank_i;
        blink_q <= blink_i;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // The first snapshot after reset is frame 0 and is not counted, so phase
  // flips together with the snapshot that starts frame BLINK_FRAMES.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (load && valid_q) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  logic                hit, sel_dp, sel_blank, sel_blink, dark;
  logic [3:0]          nib;
  logic [N_DIGITS-1:0] an_sel;

  // Digit select by compare so an unreachable idx simply finds no hit and stays dark.
  always_comb begin
    hit       = 1'b0;
    nib       = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_blink = 1'b0;
    an_sel    = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        hit       = 1'b1;
        nib       = dig_q[4*k +: 4];
        sel_dp    = dp_q[k];
        sel_blank = blank_q[k];
        sel_blink = blink_q[k];
        an_sel[k] = 1'b0;
      end
    end
    dark  = !hit || !valid_q || !enable_i || sel_blank || (phase && sel_blink);
    an_d  = dark ? '1 : an_sel;
    seg_d = dark ? 8'hFF : {~sel_dp, hex7(nib)};
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0, blank_i = '0, blink_i = '0;
  logic        enable_i = 1'b1;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  always #5 clk = ~clk;

  seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .digits_i(digits_i), .dp_i(dp_i),
    .blank_i(blank_i), .blink_i(blink_i), .enable_i(enable_i),
    .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
  );

  logic [6:0] seg7 [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model state: clock edges since reset release, plus the inputs latched at frame starts.
  int          n;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_blank, s_blink;
  int          passed = 0, total = 0;

  task automatic model_out(input logic en, output logic [3:0] an, output logic [7:0] seg);
    int idx, frame;
    bit ph;
    an  = 4'b1111;
    seg = 8'hFF;
    if (n < RD || !en) return;
    idx   = ((n / RD) - 1) % N;
    frame = ((n / RD) - 1) / N;
    ph    = BLINK_ON && (((frame / BF) % 2) == 1);
    if (s_blank[idx] || (ph && s_blink[idx])) return;
    an  = ~(4'b0001 << idx);
    seg = {~s_dp[idx], seg7[s_dig[4*idx +: 4]]};
  endtask

  task automatic step(output logic [3:0] e_an, output logic [7:0] e_seg, output logic e_fr);
    model_out(enable_i, e_an, e_seg);
    @(posedge clk);
    n++;
    e_fr = (n >= RD) && (n % RD == 0) && ((((n / RD) - 1) % N) == 0);
    if (e_fr) begin
      s_dig = digits_i; s_dp = dp_i; s_blank = blank_i; s_blink = blink_i;
    end
    #1;
  endtask

  task automatic apply_reset();
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if (an_o !== 4'b1111 || seg_o !== 8'hFF || frame_o !== 1'b0)
      $display("FAIL async_reset: an_o=%b seg_o=%h frame_o=%b, expected 1111/ff/0", an_o, seg_o, frame_o);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (an_o !== 4'b1111 || seg_o !== 8'hFF || frame_o !== 1'b0)
      $display("FAIL reset_hold: an_o=%b seg_o=%h frame_o=%b, expected 1111/ff/0", an_o, seg_o, frame_o);
    else passed++;
    rst_ni = 1'b1;
    n = 0; s_dig = '0; s_dp = '0; s_blank = '0; s_blink = '0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_first_frame();
    logic [3:0] ea; logic [7:0] es; logic ef;
    logic [3:0] c_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] c_seg [4] = '{8'hCC, 8'h86, 8'h92, 8'hCF};
    int fcount = 0;
    digits_i = 16'h1234; dp_i = '0; blank_i = '0; blink_i = '0; enable_i = 1'b1;
    apply_reset();
    repeat (19) begin
      step(ea, es, ef);
      fcount += int'(frame_o);
      total++;
      if (an_o !== ea || seg_o !== es || frame_o !== ef)
        $display("FAIL first_frame n=%0d: an_o=%b seg_o=%h frame_o=%b, expected %b/%h/%b", n, an_o, seg_o, frame_o, ea, es, ef);
      else passed++;
      if (n >= 5 && (n - 5) % 4 == 0) begin
        total++;
        if (an_o !== c_an[(n-5)/4] || seg_o !== c_seg[(n-5)/4])
          $display("FAIL first_frame_const n=%0d: an_o=%b seg_o=%h, expected %b/%h", n, an_o, seg_o, c_an[(n-5)/4], c_seg[(n-5)/4]);
        else passed++;
      end
    end
    total++;
    if (fcount != 1) $display("FAIL frame_pulses: got %0d, expected 1", fcount);
    else passed++;
  endtask

  task automatic run_checked(input string name, input int cycles);
    logic [3:0] ea; logic [7:0] es; logic ef;
    repeat (cycles) begin
      step(ea, es, ef);
      total++;
      if (an_o !== ea || seg_o !== es || frame_o !== ef)
        $display("FAIL %s n=%0d: an_o=%b seg_o=%h frame_o=%b, expected %b/%h/%b", name, n, an_o, seg_o, frame_o, ea, es, ef);
      else passed++;
    end
  endtask

  task automatic test_mid_frame_change();
    int guard = 0;
    while (an_o !== 4'b1101 && guard < 32) begin
      run_checked("mid_frame_seek", 1);
      guard++;
    end
    total++;
    if (an_o !== 4'b1101) $display("FAIL mid_frame_seek: an_o=%b, expected 1101 within 32 cycles", an_o);
    else passed++;
    digits_i = 16'hABCD;
    run_checked("mid_frame_change", 36);
  endtask

  task automatic test_dp_blank();
    dp_i = 4'b0100; blank_i = 4'b1000;
    run_checked("dp_blank", 36);
    dp_i = '0; blank_i = '0;
  endtask

  task automatic test_enable();
    run_checked("enable_pre", 6);
    enable_i = 1'b0;
    run_checked("enable_off", 6);
    enable_i = 1'b1;
    run_checked("enable_on", 36);
  endtask

  task automatic test_blink();
    digits_i = 16'h5678; blink_i = 4'b0001; dp_i = 4'b0001; blank_i = '0; enable_i = 1'b1;
    apply_reset();
    run_checked("blink", RD + 6*N*RD);
    blink_i = '0; dp_i = '0;
  endtask

  task automatic test_random();
    logic [3:0] ea; logic [7:0] es; logic ef;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        digits_i = 16'($urandom);
        dp_i     = 4'($urandom);
        blank_i  = 4'($urandom) & 4'($urandom);
        blink_i  = 4'($urandom);
      end
      enable_i = ($urandom_range(0, 9) != 0);
      step(ea, es, ef);
      total++;
      if (an_o !== ea || seg_o !== es || frame_o !== ef)
        $display("FAIL random n=%0d: an_o=%b seg_o=%h frame_o=%b, expected %b/%h/%b", n, an_o, seg_o, frame_o, ea, es, ef);
      else passed++;
    end
    enable_i = 1'b1; blank_i = '0; blink_i = '0; dp_i = '0;
  endtask

  task automatic test_async_reset_mid_digit();
    int guard = 0;
    while (an_o !== 4'b1011 && guard < 40) begin
      run_checked("reset_seek", 1);
      guard++;
    end
    total++;
    if (an_o !== 4'b1011) $display("FAIL reset_seek: an_o=%b, expected 1011 within 40 cycles", an_o);
    else passed++;
    test_first_frame();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_mid_frame_change();
    test_dp_blank();
    test_enable();
    test_blink();
    test_random();
    digits_i = 16'h1234;
    run_checked("pre_reset", 20);
    test_async_reset_mid_digit();
    run_checked("post_reset", 40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
